// File: rtl/dac_mcp492x_ctrl_if.sv
// Request/status bundle for dac_mcp492x_ctrl.
//   master: START, VALUE, GAIN_1X, BUF (+ SHDN_N when DAC_SHDN_CTRL_EN) out; BUSY, DONE in
//   slave : the reverse
// Channel A occupies VALUE[DATA_W-1:0], channel B the next DATA_W bits.
interface dac_mcp492x_ctrl_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned N_CH   = 1
);
    logic                     START;
    logic [N_CH*DATA_W-1:0]   VALUE;
    logic [N_CH-1:0]          GAIN_1X;
    logic [N_CH-1:0]          BUF;
`ifdef DAC_SHDN_CTRL_EN
    logic [N_CH-1:0]          SHDN_N;
`endif
    logic                     BUSY;
    logic                     DONE;

`ifdef DAC_SHDN_CTRL_EN
    modport master (output START, VALUE, GAIN_1X, BUF, SHDN_N, input BUSY, DONE);
    modport slave  (input START, VALUE, GAIN_1X, BUF, SHDN_N, output BUSY, DONE);
`else
    modport master (output START, VALUE, GAIN_1X, BUF, input BUSY, DONE);
    modport slave  (input START, VALUE, GAIN_1X, BUF, output BUSY, DONE);
`endif
endinterface

// File: rtl/dac_mcp492x_ctrl.sv
// SPI write controller for MCP4901/4911/4921 (single) and MCP4902/4912/4922 (dual) DACs.
// A START rising edge captures the request, shifts one 16-bit command word per channel
// (SPI mode 0, MSB first), then pulses LDAC to update all outputs together.
//   CLK, RST_N : system clock, asynchronous active-low reset
//   bus        : request/status interface (slave side)
//   CS_DAC, CLK_DAC, SDO_DAC, LDAC_DAC : DAC pins, all registered
// Optional macro DAC_SHDN_CTRL_EN adds per-channel SHDN_N; otherwise bit12 is fixed at 1.
module dac_mcp492x_ctrl #(
    parameter int unsigned CLK_DIV = 20,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned N_CH    = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    dac_mcp492x_ctrl_if.slave  bus,
    output logic               CS_DAC,
    output logic               CLK_DAC,
    output logic               SDO_DAC,
    output logic               LDAC_DAC
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PAD_W = 12 - DATA_W;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_LDAC_SETUP,
        S_LDAC_PULSE
    } state_t;

    state_t           state;
    logic             start_q;    // previous START sample
    logic             arm_q;      // blocks a START held high across reset release
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       half_cnt;   // SCK half-period index within a frame
    logic [15:0]      sr;         // frame word, bit on the wire lives at [15]
    logic [15:0]      word_b_q;
    logic             ch_q;       // 1 while sending channel B

    logic [N_CH-1:0]  shdn_c;
    logic [15:0]      word_a_c;
    logic [15:0]      word_b_c;
    logic             start_edge_c;
    logic             div_end_c;
    logic             last_c;

    // Command word: channel, BUF, GA_N, SHDN_N, data left-justified in 12 bits.
    function automatic logic [15:0] make_word(input logic ch, input logic bf, input logic ga,
                                              input logic sd, input logic [DATA_W-1:0] data);
        logic [11:0] field;
        field = 12'(data) << PAD_W;
        return {ch, bf, ga, sd, field};
    endfunction

`ifdef DAC_SHDN_CTRL_EN
    assign shdn_c = bus.SHDN_N;
`else
    assign shdn_c = '1;
`endif

    assign word_a_c = make_word(1'b0, bus.BUF[0], bus.GAIN_1X[0], shdn_c[0], bus.VALUE[DATA_W-1:0]);

    if (N_CH == 2) begin : g_dual
        assign word_b_c = make_word(1'b1, bus.BUF[N_CH-1], bus.GAIN_1X[N_CH-1], shdn_c[N_CH-1],
                                    bus.VALUE[N_CH*DATA_W-1:DATA_W]);
    end else begin : g_single
        assign word_b_c = '0;
    end

    assign start_edge_c = bus.START && !start_q && arm_q;
    assign div_end_c    = (div_cnt == DIV_LAST);
    assign last_c       = (N_CH == 1) || ch_q;

    // Frame sequencer; every DAC pin and status bit is a register here.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            arm_q    <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            sr       <= '0;
            word_b_q <= '0;
            ch_q     <= 1'b0;
            CS_DAC   <= 1'b1;
            CLK_DAC  <= 1'b0;
            SDO_DAC  <= 1'b0;
            LDAC_DAC <= 1'b1;
            bus.BUSY <= 1'b0;
            bus.DONE <= 1'b0;
        end else begin
            start_q  <= bus.START;
            arm_q    <= 1'b1;
            bus.DONE <= 1'b0;
            div_cnt  <= div_end_c ? '0 : div_cnt + DIV_W'(1);

            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    // An edge seen on the DONE cycle is dropped, not deferred.
                    if (start_edge_c && !bus.DONE) begin
                        sr       <= word_a_c;
                        word_b_q <= word_b_c;
                        ch_q     <= 1'b0;
                        half_cnt <= '0;
                        SDO_DAC  <= word_a_c[15];
                        CS_DAC   <= 1'b0;
                        bus.BUSY <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (div_end_c) begin
                        half_cnt <= half_cnt + 5'd1;
                        if (half_cnt == 5'd31) begin
                            // 16th falling edge: park SCK low and release data.
                            CLK_DAC <= 1'b0;
                            SDO_DAC <= 1'b0;
                            state   <= S_CS_HOLD;
                        end else begin
                            CLK_DAC <= ~CLK_DAC;
                            if (CLK_DAC) begin
                                sr      <= {sr[14:0], 1'b0};
                                SDO_DAC <= sr[14];
                            end
                        end
                    end
                end

                S_CS_HOLD: begin
                    if (div_end_c) begin
                        CS_DAC <= 1'b1;
                        state  <= last_c ? S_LDAC_SETUP : S_GAP;
                    end
                end

                S_GAP: begin
                    if (div_end_c) begin
                        ch_q     <= 1'b1;
                        sr       <= word_b_q;
                        SDO_DAC  <= word_b_q[15];
                        CS_DAC   <= 1'b0;
                        half_cnt <= '0;
                        state    <= S_SHIFT;
                    end
                end

                S_LDAC_SETUP: begin
                    if (div_end_c) begin
                        LDAC_DAC <= 1'b0;
                        state    <= S_LDAC_PULSE;
                    end
                end

                S_LDAC_PULSE: begin
                    if (div_end_c) begin
                        LDAC_DAC <= 1'b1;
                        bus.DONE <= 1'b1;
                        bus.BUSY <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dac_mcp492x_ctrl.md
DAC_MCP492X_CTRL -- requirements
Module: dac_mcp492x_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20: SCK half-period in CLK cycles; legal range >=2.
REQ-002 SHALL have parameter DATA_W, default 12: DAC resolution; legal values 8, 10, 12 (MCP4901/4911/4921 family).
REQ-003 SHALL have parameter N_CH, default 1: channel count; legal values 1 or 2 (MCP492x dual parts use channels A and B).
REQ-004 SHALL have port CLK, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port START, input, 1 bit: synchronous to CLK; a 0->1 transition requests one update of all channels.
REQ-007 SHALL have port VALUE, input, N_CH*DATA_W bits: channel A in [DATA_W-1:0], channel B in the next DATA_W bits.
REQ-008 SHALL have port GAIN_1X, input, N_CH bits: per-channel GA_N bit value.
REQ-009 SHALL have port BUF, input, N_CH bits: per-channel VREF buffer bit value.
REQ-010 SHALL have ports CS_DAC, CLK_DAC, SDO_DAC and LDAC_DAC, each an output of 1 bit: the SPI chip select, SPI clock, SPI data and latch signals.
REQ-011 SHALL have port BUSY, output, 1 bit: high from frame start until DONE.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse when the update completes.

Function
REQ-013 SHALL detect the START rising edge with one register; call the CLK edge where START=1 and its previous sample=0 t0-1.
REQ-014 SHALL capture VALUE, GAIN_1X, BUF and (if compiled in) SHDN_N at t0-1; later input changes SHALL NOT affect the update in progress.
REQ-015 SHALL form the 16-bit word per channel MSB first: bit15=channel (0=A, 1=B), bit14=BUF, bit13=GAIN_1X, bit12=SHDN_N, bits11:0=data left-justified with zero fill below.
REQ-016 SHALL use states IDLE -> SHIFT -> CS_HOLD -> GAP (N_CH=2, after channel A only) -> SHIFT ... -> LDAC_SETUP -> LDAC_PULSE -> IDLE.
REQ-017 SHALL drive CS_DAC low, BUSY high and SDO_DAC=bit15 at t0.
REQ-018 SHALL hold CLK_DAC idle low, raise it at t0+CLK_DIV and toggle it every CLK_DIV cycles, giving 16 rising edges per frame.
REQ-019 SHALL change SDO_DAC only on CLK_DAC falling edges, so each bit is stable for 2*CLK_DIV cycles centred on its rising edge.
REQ-020 SHALL leave CLK_DAC low after the 16th falling edge (t0+32*CLK_DIV), keep CS_DAC low for a further CLK_DIV cycles, then raise it.
REQ-021 SHALL, when N_CH=2, hold CS_DAC high for CLK_DIV cycles (GAP) and then start the channel B frame exactly as REQ-017..020.
REQ-022 SHALL, after the last frame's CS_DAC rise, wait CLK_DIV cycles, drive LDAC_DAC low for CLK_DIV cycles, then raise it.
REQ-023 SHALL drive DONE for one cycle and clear BUSY on the cycle LDAC_DAC returns high; total time t0 to DONE SHALL be 35*CLK_DIV (N_CH=1) or 69*CLK_DIV (N_CH=2).
REQ-024 SHALL ignore START edges while BUSY and SHALL NOT queue them; an edge arriving on the DONE cycle SHALL also be ignored.
REQ-025 SHALL accept a START edge on the first cycle after DONE.
REQ-026 SHALL hold SDO_DAC low while CS_DAC is high.

Reset
REQ-027 SHALL, while RST_N=0, force CS_DAC=1, CLK_DAC=0, SDO_DAC=0, LDAC_DAC=1, BUSY=0, DONE=0, state=IDLE and the edge register=0, immediately and independent of CLK.
REQ-028 SHALL, on reset mid-frame, abort the frame without an LDAC pulse; a START held high through reset release SHALL NOT trigger an update.

Configuration
REQ-029 SHALL, with macro DAC_SHDN_CTRL_EN defined, add input SHDN_N[N_CH-1:0] driving bit12 per channel; without the macro the port SHALL be absent and bit12 SHALL be fixed at 1.

Verification
REQ-030 SHALL check: N_CH=1, DATA_W=12, CLK_DIV=4, VALUE=0xABC, BUF=0, GAIN_1X=1 -> word 0x3ABC shifted MSB first, 16 SCK rises, CS high at t0+132, LDAC low at t0+136..139, DONE at t0+140.
REQ-031 SHALL check: DATA_W=8, VALUE=0xFF -> data field 0xFF0, word 0x3FF0.
REQ-032 SHALL check: N_CH=2, CLK_DIV=2, VALUE={B=0x123, A=0x456} -> frames 0x3456 then 0xB123, CS high gap of 2 cycles, a single LDAC pulse, DONE at t0+138.
REQ-033 SHALL check: second START edge at t0+10 -> ignored, exactly one frame, DONE once.
REQ-034 SHALL check: RST_N low at t0+50 -> all outputs at idle values within the same cycle, no LDAC pulse, START held high after release -> no frame.
REQ-035 SHALL check: DAC_SHDN_CTRL_EN defined, SHDN_N=0 -> bit12=0 in the word; without the macro -> bit12=1.
